// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package mem_arb_pkg;

  localparam int ARB_AW = 12;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Payload latched from the winning master and presented to the slave.
  typedef struct packed {
    logic                  we;
    logic [ARB_AW-1:0]     addr;
    logic [ARB_DW-1:0]     wdata;
    logic [ARB_DW/8-1:0]   bmask;
  } arb_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the master that did not
// win last time is chosen.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = M0;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises data-memory accesses from the core (m0) and the loader/debug
// port (m1) onto one req/ack slave, aborting stalled accesses by timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = ARB_AW,
  parameter int DW      = ARB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_m0_req,
  input  logic          i_m1_req,
  input  logic          i_m0_we,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m0_wdata,
  input  logic [DW-1:0] i_m1_wdata,
  input  logic [DW/8-1:0] i_m0_bmask,
  input  logic [DW/8-1:0] i_m1_bmask,
  output logic          o_m0_gnt,
  output logic          o_m1_gnt,
  output logic          o_m0_done,
  output logic          o_m1_done,
  output logic          o_m0_err,
  output logic          o_m1_err,
  output logic [DW-1:0] o_m0_rdata,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_s_req,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_wdata,
  output logic [DW/8-1:0] o_s_bmask,
  input  logic          i_s_ack,
  input  logic [DW-1:0] i_s_rdata
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic          own;
  logic          last;
  logic [TW-1:0] timer;
  logic          err_q;
  logic [1:0]    gnt_q;
  arb_req_t      pay;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          pick_valid;
  logic          pick_id;

  arb_rr2 u_pick (
    .req    ({i_m1_req, i_m0_req}),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // Ack is checked before the timer so a late ack on the final cycle still
  // completes cleanly instead of reporting an error.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state  <= ST_IDLE;
      own    <= M0;
      last   <= M1;
      timer  <= '0;
      err_q  <= 1'b0;
      gnt_q  <= '0;
      pay    <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state          <= ST_BUSY;
            own            <= pick_id;
            last           <= pick_id;
            timer          <= '0;
            gnt_q[pick_id] <= 1'b1;
            if (pick_id == M1) begin
              pay.we    <= i_m1_we;
              pay.addr  <= i_m1_addr;
              pay.wdata <= i_m1_wdata;
              pay.bmask <= i_m1_bmask;
            end else begin
              pay.we    <= i_m0_we;
              pay.addr  <= i_m0_addr;
              pay.wdata <= i_m0_wdata;
              pay.bmask <= i_m0_bmask;
            end
          end
        end
        ST_BUSY: begin
          if (i_s_ack) begin
            err_q <= 1'b0;
            state <= ST_DONE;
            if (!pay.we) begin
              if (own == M1) begin
                rdata1 <= i_s_rdata;
              end else begin
                rdata0 <= i_s_rdata;
              end
            end
          end else if (timer == TIMER_LAST) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_m0_gnt   = gnt_q[0];
  assign o_m1_gnt   = gnt_q[1];
  assign o_m0_done  = (state == ST_DONE) && (own == M0);
  assign o_m1_done  = (state == ST_DONE) && (own == M1);
  assign o_m0_err   = o_m0_done && err_q;
  assign o_m1_err   = o_m1_done && err_q;
  assign o_m0_rdata = rdata0;
  assign o_m1_rdata = rdata1;
  assign o_s_req    = (state == ST_BUSY);
  assign o_s_we     = pay.we;
  assign o_s_addr   = pay.addr;
  assign o_s_wdata  = pay.wdata;
  assign o_s_bmask  = pay.bmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when a
// master request is driven and retired when the matching done pulse appears.
module tb_mem_arbiter;

  localparam int AW      = 12;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [BW-1:0] m0_bmask, m1_bmask;
  logic          m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req, s_we, s_ack;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [BW-1:0] s_bmask;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_m0_req(m0_req), .i_m1_req(m1_req),
    .i_m0_we(m0_we), .i_m1_we(m1_we),
    .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
    .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
    .i_m0_bmask(m0_bmask), .i_m1_bmask(m1_bmask),
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt),
    .o_m0_done(m0_done), .o_m1_done(m1_done),
    .o_m0_err(m0_err), .o_m1_err(m1_err),
    .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
    .o_s_req(s_req), .o_s_we(s_we), .o_s_addr(s_addr),
    .o_s_wdata(s_wdata), .o_s_bmask(s_bmask),
    .i_s_ack(s_ack), .i_s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            m;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] bmask;
    logic [DW-1:0] rdata;
    bit            err;
    int            req_cycles;
  } exp_t;

  exp_t          exp_q[$];
  int            error_count = 0;
  int            check_count = 0;
  logic [DW-1:0] model_rdata [2];
  logic [DW-1:0] done_rdata [2];
  int            ack_delay = 1;
  logic [DW-1:0] slave_data = '0;
  int            w0, w1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveMaster(input bit m, input logic req, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [BW-1:0] bmask);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_bmask = bmask;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_bmask = bmask;
    end
  endtask

  // A zero or over-long ack delay means the slave never answers in time.
  task automatic pushExpected(input bit m, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [BW-1:0] bmask);
    exp_t e;
    e.m = m; e.we = we; e.addr = addr; e.wdata = wdata; e.bmask = bmask;
    e.err = (ack_delay == 0) || (ack_delay > TIMEOUT);
    e.req_cycles = e.err ? TIMEOUT : ack_delay;
    e.rdata = (we || e.err) ? model_rdata[m] : slave_data;
    model_rdata[m] = e.rdata;
    exp_q.push_back(e);
  endtask

  // Raise a request, hold it until granted, then scramble the payload.
  task automatic applyStimulus(input bit m, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [BW-1:0] bmask,
                               output int wait_cycles);
    logic g;
    driveMaster(m, 1'b1, we, addr, wdata, bmask);
    wait_cycles = 0;
    do begin
      @(negedge clk);
      wait_cycles++;
      g = m ? m1_gnt : m0_gnt;
    end while (!g && wait_cycles < 100);
    if (!g) checkOutput(m ? "gnt1_wait" : "gnt0_wait", {63'd0, g}, 64'd1);
    driveMaster(m, 1'b0, ~we, ~addr, ~wdata, ~bmask);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("drain_wait", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Slave model: ack during the ack_delay-th cycle of each o_s_req burst.
  initial begin
    int cnt = 0;
    s_ack = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      s_ack = 1'b0;
      s_rdata = '0;
      if (s_req) begin
        cnt++;
        if (ack_delay > 0 && cnt == ack_delay) begin
          s_ack = 1'b1;
          s_rdata = slave_data;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    int   req_count = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_count = 0;
      end else begin
        if (m0_gnt || m1_gnt) begin
          if (exp_q.size() == 0) begin
            checkOutput("stray_gnt", {m1_gnt, m0_gnt}, 0);
          end else begin
            checkOutput("gnt_id", {m1_gnt, m0_gnt}, exp_q[0].m ? 2'b10 : 2'b01);
            checkOutput("gnt_s_req", s_req, 1);
          end
        end
        if (s_req) begin
          req_count++;
          if (exp_q.size() != 0)
            checkOutput("s_payload", {s_we, s_addr, s_wdata, s_bmask},
                        {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata, exp_q[0].bmask});
        end
        if (m0_done || m1_done) begin
          if (exp_q.size() == 0) begin
            checkOutput("stray_done", {m1_done, m0_done}, 0);
          end else begin
            e = exp_q.pop_front();
            done_rdata[e.m] = e.rdata;
            checkOutput("done_id", {m1_done, m0_done}, e.m ? 2'b10 : 2'b01);
            checkOutput("done_err", e.m ? m1_err : m0_err, e.err);
            checkOutput("other_err", e.m ? m0_err : m1_err, 0);
            checkOutput("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
            checkOutput("other_rdata", e.m ? m0_rdata : m1_rdata, done_rdata[!e.m]);
            checkOutput("req_cycles", req_count, e.req_cycles);
            checkOutput("done_s_req", s_req, 0);
          end
          req_count = 0;
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, s_req, s_we}, 0);
    checkOutput({tag, "_payload"}, {s_addr, s_wdata, s_bmask}, 0);
    checkOutput({tag, "_rdata0"}, m0_rdata, 0);
    checkOutput({tag, "_rdata1"}, m1_rdata, 0);
  endtask

  initial begin
    model_rdata[0] = '0; model_rdata[1] = '0;
    done_rdata[0]  = '0; done_rdata[1]  = '0;
    driveMaster(0, 1'b0, 1'b0, '0, '0, '0);
    driveMaster(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Two tied rounds after reset: m0, m1, m0, m1.
    ack_delay = 1;
    for (int r = 0; r < 2; r++) begin
      slave_data = (r == 0) ? 32'h1111_0001 : 32'h2222_0002;
      pushExpected(0, 0, 12'h100 + 12'(r), '0, 4'hF);
      pushExpected(1, 0, 12'h200 + 12'(r), '0, 4'hF);
      fork
        applyStimulus(0, 0, 12'h100 + 12'(r), '0, 4'hF, w0);
        applyStimulus(1, 0, 12'h200 + 12'(r), '0, 4'hF, w1);
      join
      waitDrain();
    end

    // Plain m0 read with a three-cycle slave.
    ack_delay = 3;
    slave_data = 32'hDEAD_BEEF;
    pushExpected(0, 0, 12'h010, '0, 4'hF);
    applyStimulus(0, 0, 12'h010, '0, 4'hF, w0);
    checkOutput("t1_gnt_latency", w0, 1);
    waitDrain();
    checkOutput("t1_rdata0", m0_rdata, 32'hDEAD_BEEF);

    // m1 write leaves its read data untouched.
    ack_delay = 2;
    slave_data = 32'hBAD0_BAD0;
    pushExpected(1, 1, 12'h020, 32'h1234_5678, 4'h3);
    applyStimulus(1, 1, 12'h020, 32'h1234_5678, 4'h3, w1);
    waitDrain();
    checkOutput("t3_rdata1_kept", m1_rdata, 32'h2222_0002);

    // Silent slave: timeout, then a normal access.
    ack_delay = 0;
    pushExpected(0, 0, 12'h030, '0, 4'hF);
    applyStimulus(0, 0, 12'h030, '0, 4'hF, w0);
    waitDrain();
    ack_delay = 1;
    slave_data = 32'h0BAD_F00D;
    pushExpected(0, 0, 12'h031, '0, 4'hF);
    applyStimulus(0, 0, 12'h031, '0, 4'hF, w0);
    waitDrain();

    // Ack lands on the last permitted cycle.
    ack_delay = TIMEOUT;
    slave_data = 32'hCAFE_0016;
    pushExpected(1, 0, 12'h0FF, '0, 4'hF);
    applyStimulus(1, 0, 12'h0FF, '0, 4'hF, w1);
    waitDrain();
    checkOutput("t5_rdata1", m1_rdata, 32'hCAFE_0016);

    // Reset in the middle of a stalled access.
    ack_delay = 0;
    pushExpected(0, 0, 12'h040, '0, 4'hF);
    applyStimulus(0, 0, 12'h040, '0, 4'hF, w0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_rst");
    exp_q.delete();
    model_rdata[0] = '0; model_rdata[1] = '0;
    done_rdata[0]  = '0; done_rdata[1]  = '0;
    repeat (2) @(negedge clk);
    checkAllZero("held_rst");
    rst_n = 1'b1;
    @(negedge clk);
    ack_delay = 1;
    slave_data = 32'h5A5A_0003;
    pushExpected(0, 0, 12'h300, '0, 4'hF);
    pushExpected(1, 0, 12'h301, '0, 4'hF);
    fork
      applyStimulus(0, 0, 12'h300, '0, 4'hF, w0);
      applyStimulus(1, 0, 12'h301, '0, 4'hF, w1);
    join
    waitDrain();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
